// File: rtl/uart_matrix_loader_pkg.sv
// Shared definitions for the ASCII-hex matrix loader: FSM states, UART receiver
// states, character-class constants and matrix geometry.
package uart_matrix_loader_pkg;

    localparam int MAT_DIM   = 4;
    localparam int MAT_COUNT = 2;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        TOKEN,
        WRITE,
        DONE,
        ERROR
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_e;

    // Separator characters
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_LBRK  = 8'h5B;
    localparam logic [7:0] CH_RBRK  = 8'h5D;

    // Hex digit ranges
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_UF = 8'h46;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_LF_HEX = 8'h66;

endpackage

// File: rtl/uart_matrix_loader_decode.sv
// Combinational classifier for one received ASCII byte: hex digit, separator,
// or neither (illegal), plus the nibble value of a hex digit.
module hex_char_decode
    import uart_matrix_loader_pkg::*;
(
    input  logic [7:0] rx_byte_i,
    output logic       is_hex_o,
    output logic       is_sep_o,
    output logic [3:0] value_o
);

    always_comb begin
        is_hex_o = 1'b0;
        value_o  = 4'd0;
        if (rx_byte_i >= CH_0 && rx_byte_i <= CH_9) begin
            is_hex_o = 1'b1;
            value_o  = 4'(rx_byte_i - CH_0);
        end else if (rx_byte_i >= CH_UA && rx_byte_i <= CH_UF) begin
            is_hex_o = 1'b1;
            value_o  = 4'(rx_byte_i - CH_UA + 8'd10);
        end else if (rx_byte_i >= CH_LA && rx_byte_i <= CH_LF_HEX) begin
            is_hex_o = 1'b1;
            value_o  = 4'(rx_byte_i - CH_LA + 8'd10);
        end
    end

    assign is_sep_o = rx_byte_i inside {CH_SPACE, CH_COMMA, CH_TAB, CH_CR,
                                        CH_LF, CH_LBRK, CH_RBRK};

endmodule

// File: rtl/uart_matrix_loader.sv
// Parses a stream of whitespace/bracket separated hex tokens from a UART and
// writes each token as one SRAM word, stopping after WORD_COUNT words.
module uart_matrix_loader
    import uart_matrix_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_COUNT = MAT_COUNT * MAT_DIM * MAT_DIM,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_error,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(WORD_COUNT):0]   word_cnt
);

    localparam int CW  = $clog2(WORD_COUNT) + 1;
    localparam int DCW = $clog2(MAX_DIGITS + 1);

    ldr_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [7:0]            pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A byte parked during WRITE is consumed before any newly arriving byte.
    logic       in_vld;
    logic [7:0] in_byte;
    logic       is_hex, is_sep;
    logic [3:0] hex_val;

    assign in_vld  = pend_vld_q | rx_valid;
    assign in_byte = pend_vld_q ? pend_q : rx_byte;

    hex_char_decode u_dec (
        .rx_byte_i (in_byte),
        .is_hex_o  (is_hex),
        .is_sep_o  (is_sep),
        .value_o   (hex_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            dcnt_q     <= '0;
            wcnt_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dcnt_q     <= dcnt_d;
            wcnt_q     <= wcnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            SKIP, TOKEN: begin
                if (rx_error) begin
                    state_d = ERROR;
                end else if (in_vld) begin
                    // When the pending byte is consumed, a same-cycle arrival takes its slot.
                    pend_vld_d = pend_vld_q & rx_valid;
                    pend_d     = pend_vld_q ? rx_byte : pend_q;
                    if (is_hex) begin
                        if (state_q == SKIP) begin
                            acc_d   = DATA_WIDTH'(hex_val);
                            dcnt_d  = DCW'(1);
                            state_d = TOKEN;
                        end else if (dcnt_q == DCW'(MAX_DIGITS)) begin
                            state_d = ERROR;
                        end else begin
                            acc_d  = DATA_WIDTH'({acc_q, hex_val});
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end else if (is_sep) begin
                        if (state_q == TOKEN) begin
                            state_d = WRITE;
                            addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(wcnt_q);
                            data_d  = acc_q;
                        end
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            WRITE: begin
                wcnt_d = wcnt_q + CW'(1);
                if (rx_error)
                    state_d = ERROR;
                else if (wcnt_d == CW'(WORD_COUNT))
                    state_d = DONE;
                else
                    state_d = SKIP;
                if (rx_valid && state_d == SKIP) begin
                    pend_d     = rx_byte;
                    pend_vld_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d    = SKIP;
            acc_d      = '0;
            dcnt_d     = '0;
            wcnt_d     = '0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
        end
    end

    assign sram_we   = (state_q == WRITE);
    assign sram_addr = addr_q;
    assign sram_data = data_q;
    assign busy      = (state_q == SKIP) || (state_q == TOKEN) || (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERROR);
    assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Randomized bench for uart_matrix_loader with a token-level reference parser.
module tb_uart_matrix_loader;

    localparam int DW   = 18;
    localparam int AW   = 11;
    localparam int WC   = 32;
    localparam int MAXD = 5;

    typedef logic [7:0] ch_t;
    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int addr; int data; int sep_idx; } exp_t;

    logic          clk, reset, start, rx_valid, rx_error;
    logic [7:0]    rx_byte;
    logic          sram_we, busy, done, err;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic [5:0]    word_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ch_t  stim_q[$];
    int   sent_cyc[$];
    wr_t  got_q[$];
    exp_t exp_q[$];
    bit   exp_err, exp_done;

    uart_matrix_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_error  (rx_error),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (sram_we === 1'b1) got_q.push_back('{int'(sram_addr), int'(sram_data), cyc});

    function automatic bit c_hex(ch_t c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    function automatic bit c_sep(ch_t c);
        return c inside {8'h20, 8'h2C, 8'h09, 8'h0D, 8'h0A, 8'h5B, 8'h5D};
    endfunction

    function automatic int c_val(ch_t c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        return int'(c) - int'("A") + 10;
    endfunction

    // Reference: split stim_q into tokens and decide which words get written.
    task automatic model_run();
        int acc, nd;
        bit open;
        exp_q.delete();
        exp_err = 0; exp_done = 0; open = 0; acc = 0; nd = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (exp_err || exp_done) break;
            if (c_hex(stim_q[i])) begin
                if (open && nd == MAXD) exp_err = 1;
                else if (open) begin acc = ((acc * 16) + c_val(stim_q[i])) % (1 << DW); nd++; end
                else begin acc = c_val(stim_q[i]); nd = 1; open = 1; end
            end else if (c_sep(stim_q[i])) begin
                if (open) begin
                    exp_q.push_back('{exp_q.size(), acc, i});
                    open = 0;
                    if (exp_q.size() == WC) exp_done = 1;
                end
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(ch_t'(s[i]));
    endtask

    task automatic add_token(input int ndig);
        int v;
        for (int d = 0; d < ndig; d++) begin
            v = $urandom_range(15, 0);
            if (v < 10) stim_q.push_back(ch_t'(int'("0") + v));
            else if ($urandom_range(1, 0) == 1) stim_q.push_back(ch_t'(int'("a") + v - 10));
            else stim_q.push_back(ch_t'(int'("A") + v - 10));
        end
    endtask

    task automatic add_sep();
        ch_t seps[7];
        seps = '{8'h20, 8'h2C, 8'h09, 8'h0D, 8'h0A, 8'h5B, 8'h5D};
        stim_q.push_back(seps[$urandom_range(6, 0)]);
    endtask

    // Called just after a falling edge; one strobe per byte, gaps of gmin..gmax cycles.
    task automatic send_q(input int gmin, input int gmax);
        sent_cyc.delete();
        for (int i = 0; i < stim_q.size(); i++) begin
            rx_valid = 1'b1;
            rx_byte  = stim_q[i];
            sent_cyc.push_back(cyc);
            @(negedge clk);
            rx_valid = 1'b0;
            repeat ($urandom_range(gmax, gmin) - 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_start();
        got_q.delete();
        stim_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b expected 0", sram_we); end
        n_checks++; if (sram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0h expected 0", sram_addr); end
        n_checks++; if (sram_data !== '0) begin n_fail++; $display("FAIL reset_data got %0h expected 0", sram_data); end
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b expected 000", {busy, done, err}); end
        n_checks++; if (word_cnt !== '0) begin n_fail++; $display("FAIL reset_word_cnt got %0d expected 0", word_cnt); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b expected 0", busy); end
    endtask

    task automatic test_matrix_load();
        int sep_idx[WC];
        do_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %0b expected 1", busy); end
        for (int k = 1; k <= WC; k++) begin
            add_str($sformatf("%0h", k));
            sep_idx[k-1] = stim_q.size();
            if (k == WC) stim_q.push_back(8'h0A); else add_sep();
        end
        send_q(2, 4);
        n_checks++; if (got_q.size() !== WC) begin n_fail++; $display("FAIL load_count got %0d expected %0d", got_q.size(), WC); end
        for (int i = 0; i < WC && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].addr !== i || got_q[i].data !== i + 1 || got_q[i].cyc !== sent_cyc[sep_idx[i]] + 1) begin
                n_fail++;
                $display("FAIL load_word[%0d] got a=%0h d=%0h c=%0d expected a=%0h d=%0h c=%0d", i,
                         got_q[i].addr, got_q[i].data, got_q[i].cyc, i, i + 1, sent_cyc[sep_idx[i]] + 1);
            end
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL load_done got done=%0b busy=%0b expected 1 0", done, busy); end
        n_checks++; if (word_cnt !== 6'd32) begin n_fail++; $display("FAIL load_word_cnt got %0d expected 32", word_cnt); end
    endtask

    task automatic test_brackets();
        do_start();
        add_str("[ 3FFFF, a0 ]");
        send_q(2, 3);
        n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL brk_count got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0].addr !== 0 || got_q[0].data !== 'h3FFFF || got_q[0].cyc !== sent_cyc[7] + 1) begin
                n_fail++; $display("FAIL brk_w0 got a=%0h d=%0h c=%0d expected a=0 d=3ffff c=%0d",
                                   got_q[0].addr, got_q[0].data, got_q[0].cyc, sent_cyc[7] + 1);
            end
            n_checks++;
            if (got_q[1].addr !== 1 || got_q[1].data !== 'hA0 || got_q[1].cyc !== sent_cyc[11] + 1) begin
                n_fail++; $display("FAIL brk_w1 got a=%0h d=%0h c=%0d expected a=1 d=a0 c=%0d",
                                   got_q[1].addr, got_q[1].data, got_q[1].cyc, sent_cyc[11] + 1);
            end
        end
    endtask

    task automatic test_overlong();
        do_start();
        add_str("12345");
        send_q(2, 3);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL five_digit_err got %0b expected 0", err); end
        stim_q.delete();
        add_str("6");
        send_q(2, 2);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL six_digit_err got %0b expected 1", err); end
        stim_q.delete();
        add_str(" ");
        send_q(2, 2);
        n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL six_digit_nowrite got %0d expected 0", got_q.size()); end
        do_start();
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear got err=%0b busy=%0b expected 0 1", err, busy); end
    endtask

    task automatic test_illegal();
        do_start();
        add_str("12G ");
        send_q(2, 3);
        n_checks++; if (err !== 1'b1 || got_q.size() !== 0) begin n_fail++; $display("FAIL illegal_char got err=%0b writes=%0d expected 1 0", err, got_q.size()); end
        do_start();
        add_str("12");
        send_q(2, 3);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        stim_q.delete();
        add_str(" ");
        send_q(2, 2);
        n_checks++; if (err !== 1'b1 || got_q.size() !== 0) begin n_fail++; $display("FAIL rx_error got err=%0b writes=%0d expected 1 0", err, got_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t;
        do_start();
        add_str("5");
        send_q(2, 2);
        rx_valid = 1'b1;
        rx_byte  = 8'h20;
        t = cyc;
        @(negedge clk);
        rx_byte = "7";
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        stim_q.delete();
        add_str(" ");
        send_q(2, 2);
        n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0].addr !== 0 || got_q[0].data !== 5 || got_q[0].cyc !== t + 1) begin
                n_fail++; $display("FAIL b2b_w0 got a=%0h d=%0h c=%0d expected a=0 d=5 c=%0d", got_q[0].addr, got_q[0].data, got_q[0].cyc, t + 1);
            end
            n_checks++;
            if (got_q[1].addr !== 1 || got_q[1].data !== 7 || got_q[1].cyc !== sent_cyc[0] + 1) begin
                n_fail++; $display("FAIL b2b_w1 got a=%0h d=%0h c=%0d expected a=1 d=7 c=%0d", got_q[1].addr, got_q[1].data, got_q[1].cyc, sent_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_reset_midload();
        int n;
        do_start();
        for (int k = 0; k < 10; k++) begin add_token($urandom_range(MAXD, 1)); add_sep(); end
        send_q(2, 3);
        n_checks++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL mid_count got %0d expected 10", got_q.size()); end
        stim_q.delete();
        add_str("ab");
        send_q(2, 2);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h20;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sram_we !== 1'b0 || sram_addr !== '0 || sram_data !== '0 || {busy, done, err} !== 3'b000 || word_cnt !== '0) begin
            n_fail++; $display("FAIL mid_reset_outs got we=%0b a=%0h d=%0h bde=%b wc=%0d expected all 0",
                               sram_we, sram_addr, sram_data, {busy, done, err}, word_cnt);
        end
        reset = 1'b0;
        n = got_q.size();
        stim_q.delete();
        add_str(" c 1 ");
        send_q(2, 2);
        n_checks++; if (got_q.size() !== 10 || n !== 10) begin n_fail++; $display("FAIL mid_no_write got %0d expected 10", got_q.size()); end
        do_start();
        add_str("9 ");
        send_q(2, 2);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0].addr !== 0 || got_q[0].data !== 9) begin
            n_fail++; $display("FAIL mid_reload got n=%0d expected one write a=0 d=9", got_q.size());
        end
    endtask

    task automatic test_random();
        int nt;
        for (int it = 0; it < 6; it++) begin
            do_start();
            nt = $urandom_range(40, 5);
            for (int k = 0; k < nt; k++) begin
                if ($urandom_range(99, 0) < 3) stim_q.push_back(($urandom_range(1, 0) == 1) ? 8'h47 : 8'h2E);
                add_token(($urandom_range(99, 0) < 4) ? MAXD + 1 : $urandom_range(MAXD, 1));
                add_sep();
                if ($urandom_range(3, 0) == 0) add_sep();
            end
            model_run();
            send_q(2, 3);
            n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count got %0d expected %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
                    got_q[i].cyc !== sent_cyc[exp_q[i].sep_idx] + 1) begin
                    n_fail++; $display("FAIL rnd%0d_word[%0d] got a=%0h d=%0h c=%0d expected a=%0h d=%0h c=%0d", it, i,
                                       got_q[i].addr, got_q[i].data, got_q[i].cyc,
                                       exp_q[i].addr, exp_q[i].data, sent_cyc[exp_q[i].sep_idx] + 1);
                end
            end
            n_checks++;
            if (err !== exp_err || done !== exp_done || int'(word_cnt) !== exp_q.size()) begin
                n_fail++; $display("FAIL rnd%0d_status got err=%0b done=%0b wc=%0d expected %0b %0b %0d", it,
                                   err, done, word_cnt, exp_err, exp_done, exp_q.size());
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = '0; rx_error = 1'b0;
        test_reset();
        test_matrix_load();
        test_brackets();
        test_overlong();
        test_illegal();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_matrix_loader.md
UART_MATRIX_LOADER -- requirements
Module: uart_matrix_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 18: width of each SRAM word written.
REQ-002 Parameter ADDR_WIDTH, default 11: SRAM address width.
REQ-003 Parameter WORD_COUNT, default 32: number of words per load (two 4x4 matrices, column-major).
REQ-004 Parameter BASE_ADDR, default 0: SRAM address of the first word.
REQ-005 Parameter MAX_DIGITS, default 5: maximum hex digits per token.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins a load and clears all progress.
REQ-009 rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
REQ-010 rx_byte  input  8  received ASCII character.
REQ-011 rx_error  input  1  one-cycle strobe for a UART framing error.
REQ-012 sram_we  output  1  SRAM write enable, one cycle per word.
REQ-013 sram_addr  output  ADDR_WIDTH  write address.
REQ-014 sram_data  output  DATA_WIDTH  write data.
REQ-015 busy  output  1  high in SKIP, TOKEN and WRITE.
REQ-016 done  output  1  level; high in DONE.
REQ-017 err  output  1  level; high in ERROR.
REQ-018 word_cnt  output  $clog2(WORD_COUNT)+1  number of words written so far.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, SKIP, TOKEN, WRITE, DONE, ERROR.
REQ-020 start SHALL move any state to SKIP, clearing word_cnt, the accumulator, the digit count and the pending byte; start has priority over a same-cycle rx_valid.
REQ-021 Character classes: hex digits are 0-9, A-F and a-f; separators are space, comma, tab, CR, LF, '[' and ']'; every other byte is illegal.
REQ-022 In SKIP: a separator is ignored; a hex digit loads acc = digit value, sets digit count to 1 and moves to TOKEN.
REQ-023 In TOKEN: a hex digit sets acc = (acc << 4) | digit, truncated to DATA_WIDTH, and increments the digit count.
REQ-024 In TOKEN: a separator moves to WRITE on the next cycle.
REQ-025 An illegal byte in SKIP or TOKEN SHALL move to ERROR.
REQ-026 A digit that would make the digit count exceed MAX_DIGITS SHALL move to ERROR.
REQ-027 rx_error in SKIP, TOKEN or WRITE SHALL move to ERROR.
REQ-028 WRITE SHALL last exactly one cycle, with sram_we=1, sram_addr=BASE_ADDR+word_cnt and sram_data=acc.
REQ-029 Write latency: a separator strobed at cycle t SHALL produce sram_we=1 at cycle t+1.
REQ-030 word_cnt SHALL increment at the end of WRITE.
REQ-031 After WRITE, the FSM SHALL go to DONE if the new word_cnt equals WORD_COUNT, otherwise to SKIP.
REQ-032 An rx_valid that arrives during WRITE SHALL be latched into a one-entry pending register.
REQ-033 The pending byte SHALL be processed in the cycle after WRITE, as if it had just arrived in SKIP.
REQ-034 A pending byte processed after the final WRITE SHALL be discarded.
REQ-035 In IDLE, DONE and ERROR, rx_valid and rx_error SHALL be ignored.
REQ-036 ERROR and DONE SHALL exit only on start or reset.
REQ-037 A token that is still open when input stops SHALL never be written; a trailing separator is required.
REQ-038 sram_we SHALL be 0 in every state other than WRITE.
REQ-039 sram_addr and sram_data SHALL hold their last values outside WRITE.

Reset
REQ-040 On reset: state=IDLE, sram_we=0, sram_addr=0, sram_data=0, busy=0, done=0, err=0, word_cnt=0, acc=0, digit count=0, pending register empty.
REQ-041 Reset asserted mid-load (any state) SHALL abort with no further SRAM write, and reset SHALL take priority over start.

Structure
REQ-042 The state encoding, the character-class constants (separator set, hex ranges) and the matrix dimension constant (4) SHALL live in the shared package alongside the UART state definitions.
REQ-043 A purely combinational sub-module, hex_char_decode, SHALL map rx_byte to {is_hex, is_sep, value[3:0]}.
REQ-044 Total RTL size: 120-400 lines.

Verification
REQ-045 Scenario: start, then send "1 2 3 ... 20" (32 tokens) plus a trailing LF -> 32 writes to addresses 0..31 with data 0x1..0x20, then done=1 and word_cnt=32.
REQ-046 Scenario: send "[ 3FFFF, a0 ]" -> writes 0x3FFFF to address 0 and 0x0A0 to address 1, one cycle after the ',' and the ' ' strobes respectively.
REQ-047 Scenario: send "123456 " (six digits) -> err=1 after the sixth digit, no write occurs, and a subsequent start clears err.
REQ-048 Scenario: send "12G" -> ERROR on 'G', no write; send "12" followed by an rx_error pulse -> ERROR, no write.
REQ-049 Scenario: strobe a separator at cycle t and the digit '7' at cycle t+1 -> write at t+1 with the pending byte honoured, and the next token starts with acc=7.
REQ-050 Scenario: assert reset after 10 words have been written -> no further sram_we, all outputs at reset values; a new start reloads from address 0.
